// File: rtl/vector_cache_pkg.sv
// vector_cache_pkg
//   Shared types and constants for the vector cache read path.
//   - data_pld_t : one returned read beat (transaction ID, beat index, data)
//   - rd_line_t  : one assembled cache line (transaction ID, line data)
//   - vc_sat_add8: 8-bit saturating add used by error counters
package vector_cache_pkg;

    localparam int VC_LANES      = 8;
    localparam int VC_LINE_BEATS = 4;
    localparam int VC_TXN_NUM    = 16;
    localparam int VC_DATA_W     = 128;
    localparam int VC_TXN_W      = $clog2(VC_TXN_NUM);
    localparam int VC_BEAT_W     = $clog2(VC_LINE_BEATS);

    typedef struct packed {
        logic [VC_TXN_W-1:0]  txn_id;
        logic [VC_BEAT_W-1:0] beat_idx;
        logic [VC_DATA_W-1:0] data;
    } data_pld_t;

    typedef struct packed {
        logic [VC_TXN_W-1:0]                txn_id;
        logic [VC_LINE_BEATS*VC_DATA_W-1:0] line_data;
    } rd_line_t;

    // Saturates at 8'hFF instead of wrapping.
    function automatic logic [7:0] vc_sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/vec_cache_rr_pick.sv
// vec_cache_rr_pick
//   Round-robin first-one finder. Scans req starting at bit ptr, wrapping
//   around, and reports the first set bit.
//   Ports:
//     req : request vector
//     ptr : index where the search starts
//     gnt : one-hot grant (all zero when nothing requested)
//     idx : index of the granted bit
//     any : at least one request present
module vec_cache_rr_pick #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [31:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < N; i++) begin
            cand = (32'(ptr) + 32'(i)) % 32'(N);
            if (!any && req[cand[IW-1:0]]) begin
                any                = 1'b1;
                gnt[cand[IW-1:0]]  = 1'b1;
                idx                = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/vec_cache_rd_line_collector.sv
// vec_cache_rd_line_collector
//   Collects read beats from LANES parallel lanes, assembles them per
//   transaction ID into full lines, and presents finished lines one at a time.
//   Ports:
//     clk, rst_n  : clock; rst_n is an asynchronous ACTIVE-HIGH reset
//     beat_vld    : per-lane beat valid (no backpressure, always absorbed)
//     beat_pld    : per-lane beat payload (txn_id, beat_idx, data)
//     line_vld    : assembled line present on line_txn_id / line_data
//     line_rdy    : consumer accepts the line
//     line_txn_id : ID of the presented line
//     line_data   : line, beat k at [k*DATA_W +: DATA_W]
//     err_dup     : sticky, set when any beat is dropped
//     err_cnt     : saturating count of dropped beats
//   Handshake: a line transfers on a clock edge where line_vld && line_rdy.
//   Once line_vld is high it stays high with line_txn_id/line_data unchanged
//   until that transfer; the register may reload on the same edge, so one
//   line per cycle is possible.
module vec_cache_rd_line_collector
    import vector_cache_pkg::*;
#(
    parameter int LANES   = VC_LANES,
    parameter int TXN_NUM = VC_TXN_NUM,
    parameter int BEATS   = VC_LINE_BEATS,
    parameter int DATA_W  = VC_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES-1:0]        beat_vld,
    input  data_pld_t               beat_pld [LANES],
    output logic                    line_vld,
    input  logic                    line_rdy,
    output logic [VC_TXN_W-1:0]     line_txn_id,
    output logic [BEATS*DATA_W-1:0] line_data,
    output logic                    err_dup,
    output logic [7:0]              err_cnt
);

    localparam int TW = $clog2(TXN_NUM);

    logic [BEATS-1:0]  beat_mask [TXN_NUM];
    logic [TXN_NUM-1:0] done;
    logic [DATA_W-1:0] line_mem  [TXN_NUM][BEATS];
    logic [TW-1:0]     rr_ptr;

    logic [LANES-1:0]  keep;
    logic [LANES-1:0]  drop;
    logic [7:0]        drop_cnt;
    logic [BEATS-1:0]  set_mask  [TXN_NUM];

    logic [TXN_NUM-1:0]      pick_gnt;
    logic [TW-1:0]           pick_idx;
    logic                    pick_any;
    logic                    out_free;
    logic                    load_en;
    logic [BEATS*DATA_W-1:0] picked_data;

    // A beat survives only if its slot is still empty, its ID is not waiting
    // for output, and no lower lane claims the same (txn_id, beat_idx).
    always_comb begin
        keep     = '0;
        drop     = '0;
        drop_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            if (beat_vld[l]) begin
                keep[l] = !(beat_mask[beat_pld[l].txn_id][beat_pld[l].beat_idx] ||
                            done[beat_pld[l].txn_id]);
                for (int k = 0; k < l; k++) begin
                    if (beat_vld[k] &&
                        beat_pld[k].txn_id   == beat_pld[l].txn_id &&
                        beat_pld[k].beat_idx == beat_pld[l].beat_idx) begin
                        keep[l] = 1'b0;
                    end
                end
                drop[l] = !keep[l];
            end
            drop_cnt = drop_cnt + 8'(drop[l]);
        end
    end

    always_comb begin
        for (int t = 0; t < TXN_NUM; t++) begin
            set_mask[t] = '0;
        end
        for (int l = 0; l < LANES; l++) begin
            if (keep[l]) begin
                set_mask[beat_pld[l].txn_id][beat_pld[l].beat_idx] = 1'b1;
            end
        end
    end

    vec_cache_rr_pick #(
        .N  (TXN_NUM),
        .IW (TW)
    ) u_pick (
        .req (done),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign out_free = !line_vld || line_rdy;
    assign load_en  = out_free && pick_any;

    always_comb begin
        picked_data = '0;
        for (int b = 0; b < BEATS; b++) begin
            picked_data[b*DATA_W +: DATA_W] = line_mem[pick_idx][b];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int t = 0; t < TXN_NUM; t++) begin
                beat_mask[t] <= '0;
            end
            done        <= '0;
            rr_ptr      <= '0;
            line_vld    <= 1'b0;
            line_txn_id <= '0;
            line_data   <= '0;
            err_dup     <= 1'b0;
            err_cnt     <= '0;
        end else begin
            for (int t = 0; t < TXN_NUM; t++) begin
                // The selected ID is done, so it has no surviving beats this
                // cycle; clearing it cannot lose data.
                if (load_en && pick_gnt[t]) begin
                    beat_mask[t] <= '0;
                    done[t]      <= 1'b0;
                end else if (!done[t]) begin
                    beat_mask[t] <= beat_mask[t] | set_mask[t];
                    done[t]      <= &(beat_mask[t] | set_mask[t]);
                end
            end

            if (out_free) begin
                line_vld <= pick_any;
                if (pick_any) begin
                    line_txn_id <= VC_TXN_W'(pick_idx);
                    line_data   <= picked_data;
                    rr_ptr      <= (pick_idx == TW'(TXN_NUM - 1)) ? '0 : pick_idx + 1'b1;
                end
            end

            if (|drop) begin
                err_dup <= 1'b1;
            end
            err_cnt <= vc_sat_add8(err_cnt, drop_cnt);
        end
    end

    // Line storage carries no reset; validity lives entirely in beat_mask/done.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (keep[l]) begin
                line_mem[beat_pld[l].txn_id][beat_pld[l].beat_idx] <= beat_pld[l].data;
            end
        end
    end

endmodule

// File: tb/tb_vec_cache_rd_line_collector.sv
// Testbench for vec_cache_rd_line_collector: directed beat patterns, an
// expected-line queue filled by the driver, and a monitor that pops and
// compares on every line transfer.
module tb_vec_cache_rd_line_collector;
    import vector_cache_pkg::*;

    localparam int LANES = 8;
    localparam int BEATS = 4;
    localparam int DW    = 128;
    localparam int W     = 4 + BEATS * DW;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;   // active-high
    always #5 clk = ~clk;

    logic [LANES-1:0]   beat_vld = '0;
    data_pld_t          beat_pld [LANES];
    logic               line_vld;
    logic               line_rdy = 1'b1;
    logic [3:0]         line_txn_id;
    logic [BEATS*DW-1:0] line_data;
    logic               err_dup;
    logic [7:0]         err_cnt;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    int tests = 0;
    int fails = 0;

    vec_cache_rd_line_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .beat_vld    (beat_vld),
        .beat_pld    (beat_pld),
        .line_vld    (line_vld),
        .line_rdy    (line_rdy),
        .line_txn_id (line_txn_id),
        .line_data   (line_data),
        .err_dup     (err_dup),
        .err_cnt     (err_cnt)
    );

    // ---------------- helpers / driver tasks ----------------
    function automatic logic [W-1:0] mk_line(input logic [3:0] id, input logic [DW-1:0] d0,
                                             input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                             input logic [DW-1:0] d3);
        return {id, d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int lane, input logic [3:0] id, input logic [1:0] b,
                            input logic [DW-1:0] d);
        beat_vld[lane]          = 1'b1;
        beat_pld[lane].txn_id   = id;
        beat_pld[lane].beat_idx = b;
        beat_pld[lane].data     = d;
    endtask

    task automatic clear_beats();
        beat_vld = '0;
    endtask

    // Four beats of one ID on lanes base..base+3, data base_d+k; queues the line.
    task automatic send_line(input int base, input logic [3:0] id, input logic [DW-1:0] base_d);
        for (int k = 0; k < 4; k++) begin
            set_beat(base + k, id, 2'(k), base_d + DW'(k));
        end
        exp_q.push_back(mk_line(id, base_d, base_d + 1, base_d + 2, base_d + 3));
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 30 && (exp_q.size() != 0 || line_vld); i++) begin
            tick();
        end
        check(name, W'(exp_q.size() != 0 || line_vld), '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst_n && line_vld && line_rdy) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_line: got id %0d, expected no line", line_txn_id);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({line_txn_id, line_data} !== mon_exp) begin
                    fails++;
                    $display("FAIL line_payload: got %0h expected %0h",
                             {line_txn_id, line_data}, mon_exp);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        for (int l = 0; l < LANES; l++) begin
            beat_pld[l] = '0;
        end
        tick();
        tick();
        check("reset_line_vld", W'(line_vld), '0);
        check("reset_txn_id", W'(line_txn_id), '0);
        check("reset_line_data", W'(line_data), '0);
        check("reset_err_dup", W'(err_dup), '0);
        check("reset_err_cnt", W'(err_cnt), '0);
        rst_n = 1'b0;
        tick();

        // Basic assembly: ID 5, A0..A3, presented in cycle 2 only.
        send_line(0, 4'd5, 'hA0);
        tick();
        clear_beats();
        check("basic_c1_vld", W'(line_vld), '0);
        tick();
        check("basic_c2_vld", W'(line_vld), W'(1));
        check("basic_c2_id", W'(line_txn_id), W'(5));
        tick();
        check("basic_c3_vld", W'(line_vld), '0);
        wait_idle("basic_idle");

        // Interleaved: IDs 2 and 9 done together with rr_ptr = 0.
        do_reset();
        send_line(0, 4'd2, 'h20);
        send_line(4, 4'd9, 'h90);
        tick();
        clear_beats();
        tick();
        check("ilv_first_vld", W'(line_vld), W'(1));
        check("ilv_first_id", W'(line_txn_id), W'(2));
        tick();
        check("ilv_second_id", W'(line_txn_id), W'(9));
        tick();
        check("ilv_after_vld", W'(line_vld), '0);

        // rr_ptr is now 10: ID 11 must win over ID 5.
        send_line(4, 4'd11, 'hB0);
        send_line(0, 4'd5, 'h50);
        tick();
        clear_beats();
        tick();
        check("rr_first_id", W'(line_txn_id), W'(11));
        tick();
        check("rr_second_id", W'(line_txn_id), W'(5));
        wait_idle("rr_idle");

        // Backpressure: ID 3 held 5 cycles while ID 4 waits.
        line_rdy = 1'b0;
        send_line(0, 4'd3, 'h30);
        tick();
        clear_beats();
        send_line(0, 4'd4, 'h40);
        tick();
        clear_beats();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_vld", W'(line_vld), W'(1));
            check("bp_hold_line", {line_txn_id, line_data}, mk_line(4'd3, 'h30, 'h31, 'h32, 'h33));
            tick();
        end
        line_rdy = 1'b1;
        check("bp_release_id", W'(line_txn_id), W'(3));
        tick();
        check("bp_next_vld", W'(line_vld), W'(1));
        check("bp_next_id", W'(line_txn_id), W'(4));
        wait_idle("bp_idle");

        // Duplicate beat: second copy of ID 7 beat 1 is dropped.
        set_beat(0, 4'd7, 2'd1, 'hD1);
        tick();
        clear_beats();
        set_beat(0, 4'd7, 2'd1, 'hEE);
        set_beat(1, 4'd7, 2'd0, 'hD0);
        set_beat(2, 4'd7, 2'd2, 'hD2);
        set_beat(3, 4'd7, 2'd3, 'hD3);
        exp_q.push_back(mk_line(4'd7, 'hD0, 'hD1, 'hD2, 'hD3));
        tick();
        clear_beats();
        check("dup_err_dup", W'(err_dup), W'(1));
        check("dup_err_cnt", W'(err_cnt), W'(1));
        tick();
        check("dup_line_id", W'(line_txn_id), W'(7));
        wait_idle("dup_idle");

        // Same-cycle collision: lane 2 beats lane 6; a beat to a done ID drops.
        set_beat(2, 4'd0, 2'd0, 'h11);
        set_beat(6, 4'd0, 2'd0, 'h66);
        set_beat(0, 4'd0, 2'd1, 'h12);
        set_beat(1, 4'd0, 2'd2, 'h13);
        set_beat(3, 4'd0, 2'd3, 'h14);
        exp_q.push_back(mk_line(4'd0, 'h11, 'h12, 'h13, 'h14));
        tick();
        clear_beats();
        check("coll_err_cnt", W'(err_cnt), W'(2));
        set_beat(0, 4'd0, 2'd2, 'h77);
        tick();
        clear_beats();
        check("done_drop_err_cnt", W'(err_cnt), W'(3));
        check("coll_line_id", W'(line_txn_id), W'(0));
        wait_idle("coll_idle");

        // Saturation: all lanes hammer ID 15 beat 0.
        for (int c = 0; c < 40; c++) begin
            for (int l = 0; l < LANES; l++) begin
                set_beat(l, 4'd15, 2'd0, DW'(c));
            end
            tick();
        end
        clear_beats();
        check("sat_err_cnt", W'(err_cnt), W'(255));
        for (int l = 0; l < LANES; l++) begin
            set_beat(l, 4'd15, 2'd0, 'h5);
        end
        tick();
        clear_beats();
        check("sat_hold_err_cnt", W'(err_cnt), W'(255));

        // Reset mid-line: 3 beats for ID 1, then reset.
        set_beat(0, 4'd1, 2'd0, 'hE0);
        set_beat(1, 4'd1, 2'd1, 'hE1);
        set_beat(2, 4'd1, 2'd2, 'hE2);
        tick();
        clear_beats();
        rst_n = 1'b1;
        #1;
        check("rst_async_err_cnt", W'(err_cnt), '0);
        check("rst_async_err_dup", W'(err_dup), '0);
        tick();
        tick();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_no_line", W'(line_vld), '0);
            tick();
        end
        send_line(0, 4'd1, 'hF0);
        tick();
        clear_beats();
        tick();
        check("rst_new_vld", W'(line_vld), W'(1));
        check("rst_new_id", W'(line_txn_id), W'(1));
        wait_idle("rst_idle");
        check("rst_new_err_cnt", W'(err_cnt), '0);
        check("rst_new_err_dup", W'(err_dup), '0);

        check("final_queue_empty", W'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
